// File: rtl/irq_priority_ctrl_if.sv
// irq_priority_ctrl_if: registered valid/ready port carrying the selected interrupt ID
interface irq_priority_ctrl_if #(parameter int IDW = 4);
  logic valid;
  logic ready;
  logic [IDW-1:0] id;
  modport master(output valid, output id, input ready);
  modport slave(input valid, input id, output ready);
endinterface

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: sticky interrupt capture, masked highest-index select, valid/ready ID presentation
module irq_priority_ctrl #(
  parameter int N = 16,
  parameter int IDW = 4,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic [N-1:0] irq_in,
  input  logic [N-1:0] mask,
  output logic [N-1:0] pending,
  irq_priority_ctrl_if.master out
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_nxt;
  logic [N-1:0] irq_q, set, clr, elig;
  logic [IDW-1:0] sel, id_nxt;
  logic valid_nxt, grant, done;
  always_comb begin
    set = enable ? (EDGE_MODE ? irq_in & ~irq_q : irq_in) : '0;
    elig = pending & ~mask;
    clr = '0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = out.valid & out.ready & (out.id == IDW'(i));
      sel = elig[i] ? IDW'(i) : sel;
    end
  end
  always_comb begin
    grant = (state == IDLE) & enable & (|elig);
    done = (state == PRESENT) & out.ready;
    state_nxt = grant ? PRESENT : done ? IDLE : state;
    valid_nxt = grant ? 1'b1 : done ? 1'b0 : out.valid;
    id_nxt = grant ? sel : out.id;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      irq_q <= '0;
      out.valid <= 1'b0;
      out.id <= '0;
    end else begin
      state <= state_nxt;
      pending <= (pending & ~clr) | set;
      irq_q <= irq_in;
      out.valid <= valid_nxt;
      out.id <= id_nxt;
    end
  end
endmodule
